// File: rtl/bram_tl_host.sv
// Bridges a word-addressed valid/ready requester onto a TL-UL host port; responses retire in order.
// Optional BRAM_TL_HOST_BYPASS_EN returns an in-order D beat combinationally in the same cycle.
module bram_tl_host #(
  parameter int unsigned          DataWidth     = 32,
  parameter int unsigned          AddrWidth     = 22,
  parameter int unsigned          SourceWidth   = 2,
  parameter int unsigned          BramAddrWidth = 20,
  parameter logic [AddrWidth-1:0] BaseAddr      = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [DataWidth/8-1:0]   req_wmask_i,
  input  logic [BramAddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0]     req_wdata_i,
  output logic                     rsp_valid_o,
  output logic [DataWidth-1:0]     rsp_rdata_o,
  output logic                     rsp_error_o,
  output logic                     host_a_valid,
  input  logic                     host_a_ready,
  output logic [2:0]               host_a_opcode,
  output logic [2:0]               host_a_param,
  output logic [2:0]               host_a_size,
  output logic [SourceWidth-1:0]   host_a_source,
  output logic [AddrWidth-1:0]     host_a_address,
  output logic [DataWidth/8-1:0]   host_a_mask,
  output logic [DataWidth-1:0]     host_a_data,
  output logic                     host_a_corrupt,
  input  logic                     host_d_valid,
  output logic                     host_d_ready,
  input  logic [2:0]               host_d_opcode,
  input  logic [2:0]               host_d_param,
  input  logic [2:0]               host_d_size,
  input  logic [SourceWidth-1:0]   host_d_source,
  input  logic [0:0]               host_d_sink,
  input  logic                     host_d_denied,
  input  logic [DataWidth-1:0]     host_d_data,
  input  logic                     host_d_corrupt
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffWidth  = $clog2(StrbWidth);
  localparam int unsigned PtrWidth  = SourceWidth + 1;
  localparam int unsigned Depth     = 2 ** SourceWidth;

  localparam logic [2:0] OpPutFull     = 3'd0;
  localparam logic [2:0] OpPutPartial  = 3'd1;
  localparam logic [2:0] OpGet         = 3'd4;
  localparam logic [2:0] AccessAckData = 3'd1;

  logic [PtrWidth-1:0]    issue_q, retire_q, in_flight;
  logic [SourceWidth-1:0] retire_idx, d_offset;
  logic                   ready_en_q, rob_full, skid_free, accept;

  logic                     a_valid_q;
  logic [2:0]               a_opcode_q;
  logic [SourceWidth-1:0]   a_source_q;
  logic [AddrWidth-1:0]     a_address_q, req_byte_addr;
  logic [StrbWidth-1:0]     a_mask_q;
  logic [DataWidth-1:0]     a_data_q;
  logic [BramAddrWidth+OffWidth-1:0] word_byte_addr;

  logic [DataWidth-1:0] rob_data_q [Depth];
  logic [Depth-1:0]     rob_err_q, rob_done_q;

  logic                 rsp_valid_q, rsp_error_q;
  logic [DataWidth-1:0] rsp_rdata_q;

  logic                 d_outstanding, d_beat, d_hits_retire, d_err, rob_fire, bypass;
  logic [DataWidth-1:0] d_data_eff;
  logic                 unused_d;

  assign unused_d = ^{host_d_param, host_d_size, host_d_sink};

  assign retire_idx = retire_q[SourceWidth-1:0];
  assign in_flight  = issue_q - retire_q;
  assign rob_full   = (issue_q[PtrWidth-1] != retire_q[PtrWidth-1]) &&
                      (issue_q[SourceWidth-1:0] == retire_idx);
  assign skid_free   = !a_valid_q || host_a_ready;
  assign req_ready_o = ready_en_q && skid_free && !rob_full;
  assign accept      = req_valid_i && req_ready_o;

  assign word_byte_addr = {req_addr_i, {OffWidth{1'b0}}};
  assign req_byte_addr  = BaseAddr + AddrWidth'(word_byte_addr);

  // A source is outstanding when its distance from the retire pointer is below the in-flight count.
  assign d_offset      = host_d_source - retire_idx;
  assign d_outstanding = {1'b0, d_offset} < in_flight;
  assign d_beat        = host_d_valid && d_outstanding;
  assign d_data_eff    = (host_d_opcode == AccessAckData) ? host_d_data : '0;
  assign d_err         = host_d_denied | host_d_corrupt;
  assign d_hits_retire = d_beat && (host_d_source == retire_idx) && !rob_done_q[retire_idx];

`ifdef BRAM_TL_HOST_BYPASS_EN
  assign bypass   = d_hits_retire;
  assign rob_fire = !rsp_valid_q && rob_done_q[retire_idx];
`else
  assign bypass   = 1'b0;
  // A beat for the head entry retires straight away so latency stays at D-beat + 1.
  assign rob_fire = !rsp_valid_q && (rob_done_q[retire_idx] || d_hits_retire);
`endif

  assign host_a_valid   = a_valid_q;
  assign host_a_opcode  = a_opcode_q;
  assign host_a_param   = 3'd0;
  assign host_a_size    = 3'(OffWidth);
  assign host_a_source  = a_source_q;
  assign host_a_address = a_address_q;
  assign host_a_mask    = a_mask_q;
  assign host_a_data    = a_data_q;
  assign host_a_corrupt = 1'b0;
  assign host_d_ready   = 1'b1;

  assign rsp_valid_o = rsp_valid_q | bypass;
  assign rsp_rdata_o = bypass ? d_data_eff : rsp_rdata_q;
  assign rsp_error_o = bypass ? d_err : rsp_error_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_en_q  <= 1'b0;
      issue_q     <= '0;
      a_valid_q   <= 1'b0;
      a_opcode_q  <= OpGet;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) begin
        a_valid_q   <= 1'b1;
        a_source_q  <= issue_q[SourceWidth-1:0];
        a_address_q <= req_byte_addr;
        a_data_q    <= req_wdata_i;
        if (!req_we_i) begin
          a_opcode_q <= OpGet;
          a_mask_q   <= '1;
        end else begin
          a_opcode_q <= (&req_wmask_i) ? OpPutFull : OpPutPartial;
          a_mask_q   <= req_wmask_i;
        end
        issue_q <= issue_q + 1'b1;
      end else if (host_a_ready) begin
        a_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_q    <= '0;
      rob_err_q   <= '0;
      rob_done_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) begin
        rob_data_q[i] <= '0;
      end
    end else begin
      if (d_beat && !bypass) begin
        rob_data_q[host_d_source] <= d_data_eff;
        rob_err_q[host_d_source]  <= d_err;
        rob_done_q[host_d_source] <= 1'b1;
      end
      // Head entry is released in its pulse cycle, after any same-cycle D write.
      if (rsp_valid_q) begin
        rob_done_q[retire_idx] <= 1'b0;
      end
      if (rsp_valid_q || bypass) begin
        retire_q <= retire_q + 1'b1;
      end
      rsp_valid_q <= rob_fire;
      if (rob_fire) begin
        rsp_rdata_q <= rob_done_q[retire_idx] ? rob_data_q[retire_idx] : d_data_eff;
        rsp_error_q <= rob_done_q[retire_idx] ? rob_err_q[retire_idx] : d_err;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni && host_d_valid) begin
      assert (d_outstanding);
    end
  end
`endif

endmodule

// File: tb/tb_bram_tl_host.sv
// Directed bench for bram_tl_host: encoding, reorder, full ROB, A stall, errors, reset, latency.
module tb_bram_tl_host;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
  logic [3:0]  req_wmask_i = '0;
  logic [19:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o, rsp_error_o;
  logic [31:0] rsp_rdata_o;
  logic        host_a_valid, host_a_ready = 1'b1, host_a_corrupt;
  logic [2:0]  host_a_opcode, host_a_param, host_a_size;
  logic [1:0]  host_a_source;
  logic [21:0] host_a_address;
  logic [3:0]  host_a_mask;
  logic [31:0] host_a_data;
  logic        host_d_valid = 1'b0, host_d_ready, host_d_denied = 1'b0, host_d_corrupt = 1'b0;
  logic [2:0]  host_d_opcode = '0, host_d_param = '0, host_d_size = 3'd2;
  logic [1:0]  host_d_source = '0;
  logic [0:0]  host_d_sink = '0;
  logic [31:0] host_d_data = '0;

`ifdef BRAM_TL_HOST_BYPASS_EN
  localparam int ExpLat = 0;
`else
  localparam int ExpLat = 1;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] rsp_data_q[$];
  logic        rsp_err_q[$];
  int          rsp_cyc_q[$];
  logic [21:0] a_addr_log[$];

  bram_tl_host #(
    .DataWidth    (32),
    .AddrWidth    (22),
    .SourceWidth  (2),
    .BramAddrWidth(20),
    .BaseAddr     (22'h0C0000)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_wmask_i   (req_wmask_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_error_o   (rsp_error_o),
    .host_a_valid  (host_a_valid),
    .host_a_ready  (host_a_ready),
    .host_a_opcode (host_a_opcode),
    .host_a_param  (host_a_param),
    .host_a_size   (host_a_size),
    .host_a_source (host_a_source),
    .host_a_address(host_a_address),
    .host_a_mask   (host_a_mask),
    .host_a_data   (host_a_data),
    .host_a_corrupt(host_a_corrupt),
    .host_d_valid  (host_d_valid),
    .host_d_ready  (host_d_ready),
    .host_d_opcode (host_d_opcode),
    .host_d_param  (host_d_param),
    .host_d_size   (host_d_size),
    .host_d_source (host_d_source),
    .host_d_sink   (host_d_sink),
    .host_d_denied (host_d_denied),
    .host_d_data   (host_d_data),
    .host_d_corrupt(host_d_corrupt)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (rsp_valid_o) begin
      rsp_data_q.push_back(rsp_rdata_o);
      rsp_err_q.push_back(rsp_error_o);
      rsp_cyc_q.push_back(cyc);
    end
    if (host_a_valid && host_a_ready) a_addr_log.push_back(host_a_address);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_logs();
    rsp_data_q.delete();
    rsp_err_q.delete();
    rsp_cyc_q.delete();
    a_addr_log.delete();
  endtask

  task automatic reset_dut();
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    host_d_valid = 1'b0;
    host_a_ready = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step();
    step();
    clear_logs();
  endtask

  // Holds a request until accepted; returns just after the accepting edge.
  task automatic issue(input logic we, input logic [3:0] mask, input logic [19:0] addr,
                       input logic [31:0] wdata);
    int n = 0;
    req_valid_i = 1'b1;
    req_we_i = we;
    req_wmask_i = mask;
    req_addr_i = addr;
    req_wdata_i = wdata;
    while (!req_ready_o && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!req_ready_o) begin
      failures++;
      $display("FAIL req_accept_timeout addr=%h ready=%b required=1", addr, req_ready_o);
    end else begin
      step();
    end
    req_valid_i = 1'b0;
  endtask

  task automatic send_d(input logic [1:0] src, input logic [2:0] op, input logic [31:0] data,
                        input logic denied);
    host_d_valid = 1'b1;
    host_d_source = src;
    host_d_opcode = op;
    host_d_data = data;
    host_d_denied = denied;
    step();
    host_d_valid = 1'b0;
    host_d_denied = 1'b0;
  endtask

  task automatic wait_rsps(input int n);
    int k = 0;
    while (rsp_data_q.size() < n && k < 40) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    checks++;
    if ({req_ready_o, host_a_valid, rsp_valid_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=000", {req_ready_o, host_a_valid, rsp_valid_o});
    end
    reset_dut();
    checks++;
    if (req_ready_o !== 1'b1 || host_d_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got=%b%b required=11", req_ready_o, host_d_ready);
    end
  endtask

  task automatic test_single_read();
    int d_cyc;
    clear_logs();
    issue(1'b0, 4'h0, 20'h10, 32'h0);
    checks++;
    if ({host_a_valid, host_a_opcode, host_a_address, host_a_mask, host_a_source, host_a_size,
         host_a_param, host_a_corrupt} !== {1'b1, 3'd4, 22'h0C0040, 4'hF, 2'd0, 3'd2, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL get_a_fields got v=%b op=%0d addr=%h mask=%h src=%0d size=%0d required 1 4 0c0040 f 0 2",
               host_a_valid, host_a_opcode, host_a_address, host_a_mask, host_a_source, host_a_size);
    end
    step();
    checks++;
    if (host_a_valid !== 1'b0) begin
      failures++;
      $display("FAIL get_a_drop got=%b required=0", host_a_valid);
    end
    d_cyc = cyc;
    send_d(2'd0, 3'd1, 32'hDEADBEEF, 1'b0);
    wait_rsps(1);
    step();
    step();
    checks++;
    if (rsp_data_q.size() != 1) begin
      failures++;
      $display("FAIL single_rsp_count got=%0d required=1", rsp_data_q.size());
    end else begin
      checks++;
      if ({rsp_data_q[0], rsp_err_q[0]} !== {32'hDEADBEEF, 1'b0}) begin
        failures++;
        $display("FAIL single_rsp_data got=%h err=%b required=deadbeef err=0",
                 rsp_data_q[0], rsp_err_q[0]);
      end
      checks++;
      if (rsp_cyc_q[0] - d_cyc != ExpLat) begin
        failures++;
        $display("FAIL rsp_latency got=%0d required=%0d", rsp_cyc_q[0] - d_cyc, ExpLat);
      end
    end
  endtask

  task automatic test_writes();
    clear_logs();
    issue(1'b1, 4'hF, 20'h20, 32'h11223344);
    checks++;
    if ({host_a_opcode, host_a_mask, host_a_data, host_a_address, host_a_source} !==
        {3'd0, 4'hF, 32'h11223344, 22'h0C0080, 2'd1}) begin
      failures++;
      $display("FAIL put_full got op=%0d mask=%h data=%h addr=%h src=%0d required 0 f 11223344 0c0080 1",
               host_a_opcode, host_a_mask, host_a_data, host_a_address, host_a_source);
    end
    issue(1'b1, 4'h3, 20'h21, 32'h55667788);
    checks++;
    if ({host_a_opcode, host_a_mask, host_a_data, host_a_address, host_a_source} !==
        {3'd1, 4'h3, 32'h55667788, 22'h0C0084, 2'd2}) begin
      failures++;
      $display("FAIL put_partial got op=%0d mask=%h data=%h addr=%h src=%0d required 1 3 55667788 0c0084 2",
               host_a_opcode, host_a_mask, host_a_data, host_a_address, host_a_source);
    end
    step();
    send_d(2'd1, 3'd0, 32'hFFFFFFFF, 1'b0);
    send_d(2'd2, 3'd0, 32'hFFFFFFFF, 1'b0);
    wait_rsps(2);
    checks++;
    if (rsp_data_q.size() != 2) begin
      failures++;
      $display("FAIL write_rsp_count got=%0d required=2", rsp_data_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({rsp_data_q[i], rsp_err_q[i]} !== 33'h0) begin
          failures++;
          $display("FAIL write_rsp%0d got=%h err=%b required=0 err=0", i, rsp_data_q[i], rsp_err_q[i]);
        end
      end
    end
  endtask

  task automatic test_reorder();
    logic [1:0] order [4];
    order[0] = 2'd3;
    order[1] = 2'd1;
    order[2] = 2'd0;
    order[3] = 2'd2;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 4'h0, 20'h100 + 20'(i), 32'h0);
      checks++;
      if (host_a_source !== 2'(i)) begin
        failures++;
        $display("FAIL reorder_src%0d got=%0d required=%0d", i, host_a_source, i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL full_ready cycle=%0d got=%b required=0", i, req_ready_o);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        checks++;
        if (req_ready_o !== 1'b0 || rsp_data_q.size() != 0) begin
          failures++;
          $display("FAIL full_before_head got ready=%b rsps=%0d required ready=0 rsps=0",
                   req_ready_o, rsp_data_q.size());
        end
      end
      send_d(order[i], 3'd1, 32'hA0 + 32'(order[i]), 1'b0);
    end
    wait_rsps(4);
    checks++;
    if (rsp_data_q.size() != 4) begin
      failures++;
      $display("FAIL reorder_count got=%0d required=4", rsp_data_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rsp_data_q[i] !== 32'hA0 + 32'(i)) begin
          failures++;
          $display("FAIL reorder_rsp%0d got=%h required=%h", i, rsp_data_q[i], 32'hA0 + 32'(i));
        end
      end
    end
    step();
    step();
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_drain got=%b required=1", req_ready_o);
    end
  endtask

  task automatic test_a_stall();
    clear_logs();
    host_a_ready = 1'b0;
    issue(1'b0, 4'h0, 20'h5, 32'h0);
    req_valid_i = 1'b1;
    req_we_i = 1'b0;
    req_addr_i = 20'h6;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({host_a_valid, host_a_opcode, host_a_address, host_a_source, host_a_mask, req_ready_o} !==
          {1'b1, 3'd4, 22'h0C0014, 2'd0, 4'hF, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold%0d got v=%b op=%0d addr=%h src=%0d ready=%b required 1 4 0c0014 0 0",
                 i, host_a_valid, host_a_opcode, host_a_address, host_a_source, req_ready_o);
      end
      step();
    end
    host_a_ready = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ready got=%b required=1", req_ready_o);
    end
    step();
    req_valid_i = 1'b0;
    checks++;
    if ({host_a_valid, host_a_address, host_a_source} !== {1'b1, 22'h0C0018, 2'd1}) begin
      failures++;
      $display("FAIL stall_second got v=%b addr=%h src=%0d required 1 0c0018 1",
               host_a_valid, host_a_address, host_a_source);
    end
    step();
    checks++;
    if (a_addr_log.size() != 2) begin
      failures++;
      $display("FAIL stall_a_count got=%0d required=2", a_addr_log.size());
    end else begin
      checks++;
      if ({a_addr_log[0], a_addr_log[1]} !== {22'h0C0014, 22'h0C0018}) begin
        failures++;
        $display("FAIL stall_a_order got=%h,%h required=0c0014,0c0018", a_addr_log[0], a_addr_log[1]);
      end
    end
    send_d(2'd0, 3'd1, 32'h50, 1'b0);
    send_d(2'd1, 3'd1, 32'h60, 1'b0);
    wait_rsps(2);
    checks++;
    if (rsp_data_q.size() != 2 || rsp_data_q[0] !== 32'h50 || rsp_data_q[1] !== 32'h60) begin
      failures++;
      $display("FAIL stall_rsps got count=%0d required 50,60", rsp_data_q.size());
    end
  endtask

  task automatic test_error_and_reset();
    clear_logs();
    issue(1'b0, 4'h0, 20'h7, 32'h0);
    step();
    send_d(2'd2, 3'd1, 32'h77, 1'b1);
    wait_rsps(1);
    checks++;
    if (rsp_data_q.size() != 1 || rsp_err_q[0] !== 1'b1 || rsp_data_q[0] !== 32'h77) begin
      failures++;
      $display("FAIL denied_rsp got count=%0d required count=1 err=1 data=77", rsp_data_q.size());
    end
    clear_logs();
    issue(1'b0, 4'h0, 20'h8, 32'h0);
    issue(1'b0, 4'h0, 20'h9, 32'h0);
    host_a_ready = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({host_a_valid, req_ready_o, rsp_valid_o} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%b required=000", {host_a_valid, req_ready_o, rsp_valid_o});
    end
    step();
    rst_ni = 1'b1;
    host_a_ready = 1'b1;
    repeat (5) step();
    checks++;
    if (rsp_data_q.size() != 0 || host_a_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_drop got rsps=%0d a_valid=%b required 0 0", rsp_data_q.size(), host_a_valid);
    end
    issue(1'b0, 4'h0, 20'hA, 32'h0);
    checks++;
    if ({host_a_source, host_a_address} !== {2'd0, 22'h0C0028}) begin
      failures++;
      $display("FAIL post_reset_src got src=%0d addr=%h required 0 0c0028", host_a_source, host_a_address);
    end
    step();
    send_d(2'd0, 3'd1, 32'hAA, 1'b0);
    wait_rsps(1);
    checks++;
    if (rsp_data_q.size() != 1 || rsp_data_q[0] !== 32'hAA) begin
      failures++;
      $display("FAIL post_reset_rsp got count=%0d required count=1 data=aa", rsp_data_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_writes();
    test_reorder();
    test_a_stall();
    test_error_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
